// File: rtl/i2s_apb_fifo_bridge.sv
// ---------------------------------------------------------------------------
// i2s_apb_fifo_bridge
//
// APB-programmable sample buffer between a CPU/DMA and an I2S shifter pair.
// A TX FIFO is filled by APB writes and drained by the playback shifter. An RX
// FIFO is filled by the capture shifter and drained by APB reads. Watermark
// interrupts, sticky underrun/overrun flags and DMA request lines are included.
//
// Parameters
//   DATA_W  sample width in bits (8..32)
//   DEPTH   entries per FIFO, power of two (4..128)
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   psel/penable/pwrite      APB control
//   paddr[4:0], pwdata[31:0] APB byte address and write data
//   prdata[31:0]             APB read data (combinational, 0 outside reads)
//   pready, pslverr          APB ready (no wait states) and error
//   tx_data/tx_valid         playback sample at the TX head
//   tx_ready                 playback shifter pop strobe
//   rx_data/rx_valid         capture sample push (no backpressure)
//   tx_dma_req/tx_dma_ack    TX DMA handshake
//   rx_dma_req/rx_dma_ack    RX DMA handshake
//   irq                      registered level interrupt
//
// Register map (byte addresses)
//   0x00 DATA   W: push TX, R: pop RX (zero-extended)
//   0x04 STATUS RO {rx_level, rx_full, rx_empty, tx_level, tx_full, tx_empty}
//   0x08 CTRL   [0] TX_CLR [1] TX_DMA_EN [2] RX_CLR [3] RX_DMA_EN
//               [4] TX_EN  [5] RX_EN     [11:8] IE
//   0x0C WMARK  [7:0] tx_wm, [23:16] rx_wm
//   0x10 ISR    [0] TX wmark [1] RX wmark (live), [2] TX underrun,
//               [3] RX overrun (sticky, write-1-to-clear)
// ---------------------------------------------------------------------------
module i2s_apb_fifo_bridge #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [4:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              tx_dma_req,
    output logic              rx_dma_req,
    input  logic              tx_dma_ack,
    input  logic              rx_dma_ack,
    output logic              irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [4:0] {
        REG_DATA   = 5'h00,
        REG_STATUS = 5'h04,
        REG_CTRL   = 5'h08,
        REG_WMARK  = 5'h0C,
        REG_ISR    = 5'h10
    } reg_addr_e;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic access, wr_access, rd_access;
    logic hit_data, hit_status, hit_ctrl, hit_wmark, hit_isr, hit_mapped;

    always_comb begin
        access     = psel & penable;
        wr_access  = access & pwrite;
        rd_access  = access & ~pwrite;
        hit_data   = (paddr == REG_DATA);
        hit_status = (paddr == REG_STATUS);
        hit_ctrl   = (paddr == REG_CTRL);
        hit_wmark  = (paddr == REG_WMARK);
        hit_isr    = (paddr == REG_ISR);
        hit_mapped = hit_data | hit_status | hit_ctrl | hit_wmark | hit_isr;
    end

    assign pready = penable;

    // ------------------------------------------------------------------
    // Control / watermark registers
    // ------------------------------------------------------------------
    logic          tx_dma_en, rx_dma_en, tx_en, rx_en;
    logic [3:0]    ie;
    logic [LW-1:0] tx_wm, rx_wm;
    logic          ctrl_wr, wmark_wr, isr_wr;

    always_comb begin
        ctrl_wr  = wr_access & hit_ctrl;
        wmark_wr = wr_access & hit_wmark;
        isr_wr   = wr_access & hit_isr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_dma_en <= 1'b0;
            rx_dma_en <= 1'b0;
            tx_en     <= 1'b0;
            rx_en     <= 1'b0;
            ie        <= '0;
        end else if (ctrl_wr) begin
            tx_dma_en <= pwdata[1];
            rx_dma_en <= pwdata[3];
            tx_en     <= pwdata[4];
            rx_en     <= pwdata[5];
            ie        <= pwdata[11:8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wm <= '0;
            rx_wm <= '0;
        end else if (wmark_wr) begin
            tx_wm <= pwdata[LW-1:0];
            rx_wm <= pwdata[16 +: LW];
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (APB -> playback)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [AW-1:0]     tx_wptr, tx_rptr;
    logic [LW-1:0]     tx_level;
    logic              tx_empty, tx_full;
    logic              tx_push, tx_pop, tx_clr, tx_underrun;

    always_comb begin
        tx_empty    = (tx_level == '0);
        tx_full     = (tx_level == FULL_LEVEL);
        tx_valid    = tx_en & ~tx_empty;
        // Full check uses the level before this edge, so a same-cycle pop
        // does not make room for a write that arrived while full.
        tx_push     = wr_access & hit_data & ~tx_full;
        tx_pop      = tx_ready & tx_valid;
        tx_clr      = ctrl_wr & pwdata[0];
        tx_underrun = tx_ready & tx_en & tx_empty;
    end

    assign tx_data = tx_mem[tx_rptr];

    always_ff @(posedge clk) begin
        if (tx_push && !tx_clr) begin
            tx_mem[tx_wptr] <= pwdata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_level <= '0;
        end else if (tx_clr) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            unique case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + 1'b1;
                2'b01:   tx_level <= tx_level - 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (capture -> APB)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [AW-1:0]     rx_wptr, rx_rptr;
    logic [LW-1:0]     rx_level;
    logic              rx_empty, rx_full;
    logic              rx_push, rx_pop, rx_clr, rx_overrun;

    always_comb begin
        rx_empty   = (rx_level == '0);
        rx_full    = (rx_level == FULL_LEVEL);
        rx_push    = rx_valid & rx_en & ~rx_full;
        rx_overrun = rx_valid & rx_en & rx_full;
        rx_pop     = rd_access & hit_data & ~rx_empty;
        rx_clr     = ctrl_wr & pwdata[2];
    end

    always_ff @(posedge clk) begin
        if (rx_push && !rx_clr) begin
            rx_mem[rx_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_level <= '0;
        end else if (rx_clr) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_level <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            unique case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Interrupt status
    // ------------------------------------------------------------------
    logic       underrun_flag, overrun_flag;
    logic       tx_wm_hit, rx_wm_hit;
    logic [3:0] isr;

    always_comb begin
        tx_wm_hit = (tx_level <= tx_wm);
        rx_wm_hit = (rx_wm != '0) && (rx_level >= rx_wm);
        isr       = {overrun_flag, underrun_flag, rx_wm_hit, tx_wm_hit};
    end

    // A new event in the same cycle as a W1C wins so it is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_flag <= 1'b0;
            overrun_flag  <= 1'b0;
        end else begin
            underrun_flag <= tx_underrun | (underrun_flag & ~(isr_wr & pwdata[2]));
            overrun_flag  <= rx_overrun  | (overrun_flag  & ~(isr_wr & pwdata[3]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(isr & ie);
        end
    end

    // ------------------------------------------------------------------
    // DMA requests: an ack forces one low cycle so the engine can resample.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_dma_req <= 1'b0;
            rx_dma_req <= 1'b0;
        end else begin
            tx_dma_req <= ~tx_dma_ack & tx_dma_en & tx_wm_hit & ~tx_full;
            rx_dma_req <= ~rx_dma_ack & rx_dma_en & rx_wm_hit;
        end
    end

    // ------------------------------------------------------------------
    // Read data and error response
    // ------------------------------------------------------------------
    logic [7:0]  tx_level_b, rx_level_b, tx_wm_b, rx_wm_b;
    logic [31:0] rx_head_w;
    logic [31:0] status_word, ctrl_word, wmark_word, isr_word;

    always_comb begin
        tx_level_b           = '0;
        rx_level_b           = '0;
        tx_wm_b              = '0;
        rx_wm_b              = '0;
        rx_head_w            = '0;
        tx_level_b[LW-1:0]   = tx_level;
        rx_level_b[LW-1:0]   = rx_level;
        tx_wm_b[LW-1:0]      = tx_wm;
        rx_wm_b[LW-1:0]      = rx_wm;
        rx_head_w[DATA_W-1:0] = rx_mem[rx_rptr];

        status_word = {rx_level_b, 6'b0, rx_full, rx_empty,
                       tx_level_b, 6'b0, tx_full, tx_empty};
        ctrl_word   = {20'b0, ie, 2'b0, rx_en, tx_en, rx_dma_en, 1'b0, tx_dma_en, 1'b0};
        wmark_word  = {8'b0, rx_wm_b, 8'b0, tx_wm_b};
        isr_word    = {28'b0, isr};
    end

    always_comb begin
        prdata = '0;
        if (rd_access) begin
            case (paddr)
                REG_DATA:   prdata = rx_empty ? '0 : rx_head_w;
                REG_STATUS: prdata = status_word;
                REG_CTRL:   prdata = ctrl_word;
                REG_WMARK:  prdata = wmark_word;
                REG_ISR:    prdata = isr_word;
                default:    prdata = '0;
            endcase
        end
    end

    always_comb begin
        pslverr = 1'b0;
        if (access) begin
            pslverr = ~hit_mapped
                    | (pwrite  & hit_status)
                    | (pwrite  & hit_data & tx_full)
                    | (~pwrite & hit_data & rx_empty);
        end
    end

endmodule

// File: tb/tb_i2s_apb_fifo_bridge.sv
// ---------------------------------------------------------------------------
// tb_i2s_apb_fifo_bridge
//
// Directed self-checking bench for i2s_apb_fifo_bridge (DATA_W=32, DEPTH=16).
// Each scenario task drives stimulus and compares against hand-derived values.
// ---------------------------------------------------------------------------
module tb_i2s_apb_fifo_bridge;

    logic        clk, reset_n;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [31:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid;
    logic        tx_dma_req, rx_dma_req, tx_dma_ack, rx_dma_ack, irq;

    int          total = 0;
    int          bad   = 0;
    logic        err;
    logic [31:0] rd;
    logic        last_ready;
    logic [31:0] q[$];
    logic [31:0] exp_w;
    logic        pop, push_ok;

    i2s_apb_fifo_bridge #(.DATA_W(32), .DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_dma_req(tx_dma_req), .rx_dma_req(rx_dma_req),
        .tx_dma_ack(tx_dma_ack), .rx_dma_ack(rx_dma_ack),
        .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 e = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; e = pslverr; last_ready = pready;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({tx_valid, pslverr, irq, tx_dma_req, rx_dma_req} !== 5'b0) begin
            bad++; $display("FAIL reset_outs: got %b exp 00000", {tx_valid, pslverr, irq, tx_dma_req, rx_dma_req});
        end
        reset_n = 1'b1;
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_0001) begin bad++; $display("FAIL reset_status: got %h exp 00010001", rd); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_status_err: got %b exp 0", err); end
        total++; if (last_ready !== 1'b1) begin bad++; $display("FAIL pready_access: got %b exp 1", last_ready); end
        total++; if (pready !== 1'b0) begin bad++; $display("FAIL pready_idle: got %b exp 0", pready); end
        apb_read(5'h08, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h exp 0", rd); end
        apb_read(5'h0C, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_wmark: got %h exp 0", rd); end
        apb_read(5'h10, rd, err);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL reset_isr: got %h exp 1", rd); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 17; i++) begin
            apb_write(5'h00, 32'h1000 + i, err);
            total++; if (err !== (i == 16)) begin
                bad++; $display("FAIL fill_err[%0d]: got %b exp %b", i, err, (i == 16));
            end
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fill_valid_dis: got %b exp 0", tx_valid); end
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_1002) begin bad++; $display("FAIL fill_status: got %h exp 00011002", rd); end
        apb_write(5'h08, 32'h10, err);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total++; if (tx_valid !== 1'b1 || tx_data !== 32'h1000 + i) begin
                bad++; $display("FAIL fill_pop[%0d]: got %b/%h exp 1/%h", i, tx_valid, tx_data, 32'h1000 + i);
            end
            tx_ready = 1'b1;
        end
        @(negedge clk);
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fill_drained: got %b exp 0", tx_valid); end
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_0001) begin bad++; $display("FAIL fill_empty: got %h exp 00010001", rd); end
        apb_read(5'h10, rd, err);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL fill_isr: got %h exp 1", rd); end
    endtask

    task automatic test_dma;
        apb_write(5'h0C, 32'h4, err);
        apb_write(5'h08, 32'h2, err);
        for (int i = 0; i < 3; i++) apb_write(5'h00, 32'h50 + i, err);
        @(negedge clk);
        total++; if (tx_dma_req !== 1'b1) begin bad++; $display("FAIL dma_lvl3: got %b exp 1", tx_dma_req); end
        tx_dma_ack = 1'b1;
        @(negedge clk);
        tx_dma_ack = 1'b0;
        total++; if (tx_dma_req !== 1'b0) begin bad++; $display("FAIL dma_ack_low: got %b exp 0", tx_dma_req); end
        @(negedge clk);
        total++; if (tx_dma_req !== 1'b1) begin bad++; $display("FAIL dma_reassert: got %b exp 1", tx_dma_req); end
        apb_write(5'h00, 32'h53, err);
        apb_write(5'h00, 32'h54, err);
        @(negedge clk);
        total++; if (tx_dma_req !== 1'b1) begin bad++; $display("FAIL dma_lag: got %b exp 1", tx_dma_req); end
        @(negedge clk);
        total++; if (tx_dma_req !== 1'b0) begin bad++; $display("FAIL dma_lvl5: got %b exp 0", tx_dma_req); end
        apb_read(5'h10, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL dma_isr: got %h exp 0", rd); end
        apb_write(5'h08, 32'h1, err);
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_0001) begin bad++; $display("FAIL dma_clr_status: got %h exp 00010001", rd); end
    endtask

    task automatic test_overrun;
        apb_write(5'h08, 32'h820, err);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rx_valid = 1'b1; rx_data = 32'h2000 + i;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ovr_irq_lag: got %b exp 0", irq); end
        @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ovr_irq: got %b exp 1", irq); end
        apb_read(5'h10, rd, err);
        total++; if (rd !== 32'h9) begin bad++; $display("FAIL ovr_isr: got %h exp 9", rd); end
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h1002_0001) begin bad++; $display("FAIL ovr_status: got %h exp 10020001", rd); end
        apb_write(5'h10, 32'h8, err);
        @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_lag: got %b exp 1", irq); end
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b exp 0", irq); end
        apb_read(5'h10, rd, err);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL w1c_isr: got %h exp 1", rd); end
        for (int i = 0; i < 16; i++) begin
            apb_read(5'h00, rd, err);
            total++; if (rd !== 32'h2000 + i || err !== 1'b0) begin
                bad++; $display("FAIL rx_pop[%0d]: got %h/%b exp %h/0", i, rd, err, 32'h2000 + i);
            end
        end
        // empty read with a simultaneous capture push
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 5'h00;
        @(negedge clk);
        penable = 1'b1; rx_valid = 1'b1; rx_data = 32'hABCD;
        #1;
        total++; if (pslverr !== 1'b1 || prdata !== 32'h0) begin
            bad++; $display("FAIL rx_empty_rd: got %b/%h exp 1/0", pslverr, prdata);
        end
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
        apb_read(5'h00, rd, err);
        total++; if (rd !== 32'hABCD || err !== 1'b0) begin bad++; $display("FAIL rx_simul_push: got %h/%b exp abcd/0", rd, err); end
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_0001) begin bad++; $display("FAIL rx_final_status: got %h exp 00010001", rd); end
        apb_write(5'h08, 32'h0, err);
    endtask

    task automatic test_wrap;
        apb_write(5'h08, 32'h10, err);
        q.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = $urandom;
            pop = ($urandom_range(0, 1) == 1) && (q.size() > 0);
            tx_ready = pop;
            total++; if (tx_valid !== (q.size() > 0) || (q.size() > 0 && tx_data !== q[0])) begin
                bad++; $display("FAIL wrap_head_a[%0d]: got %b/%h exp %b/%h", i, tx_valid, tx_data, q.size() > 0, (q.size() > 0) ? q[0] : 32'h0);
            end
            @(posedge clk);
            if (pop) void'(q.pop_front());
            @(negedge clk);
            penable = 1'b1;
            pop = ($urandom_range(0, 1) == 1) && (q.size() > 0);
            tx_ready = pop;
            push_ok = (q.size() < 16);
            #1;
            total++; if (pslverr !== !push_ok) begin
                bad++; $display("FAIL wrap_err[%0d]: got %b exp %b", i, pslverr, !push_ok);
            end
            total++; if (tx_valid !== (q.size() > 0) || (q.size() > 0 && tx_data !== q[0])) begin
                bad++; $display("FAIL wrap_head_b[%0d]: got %b/%h exp %b/%h", i, tx_valid, tx_data, q.size() > 0, (q.size() > 0) ? q[0] : 32'h0);
            end
            @(posedge clk);
            if (pop) void'(q.pop_front());
            if (push_ok) q.push_back(pwdata);
            #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_ready = 1'b0;
        end
        exp_w = 32'h0001_0000 | (32'(q.size()) << 8) | ((q.size() == 16) ? 32'h2 : 32'h0) | ((q.size() == 0) ? 32'h1 : 32'h0);
        apb_read(5'h04, rd, err);
        total++; if (rd !== exp_w) begin bad++; $display("FAIL wrap_level: got %h exp %h", rd, exp_w); end
        while (q.size() > 0) begin
            @(negedge clk);
            total++; if (tx_data !== q[0]) begin bad++; $display("FAIL wrap_drain: got %h exp %h", tx_data, q[0]); end
            tx_ready = 1'b1;
            @(posedge clk);
            void'(q.pop_front());
        end
        @(negedge clk);
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty: got %b exp 0", tx_valid); end
        // push and pop in one cycle at level 8
        for (int i = 0; i < 8; i++) apb_write(5'h00, 32'h3000 + i, err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'h3008;
        @(negedge clk);
        penable = 1'b1; tx_ready = 1'b1;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_ready = 1'b0;
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_0800) begin bad++; $display("FAIL simul_level8: got %h exp 00010800", rd); end
        total++; if (tx_data !== 32'h3001) begin bad++; $display("FAIL simul_head: got %h exp 3001", tx_data); end
        apb_write(5'h08, 32'h11, err);
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_0001) begin bad++; $display("FAIL wrap_clr: got %h exp 00010001", rd); end
    endtask

    task automatic test_clear;
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        apb_read(5'h10, rd, err);
        total++; if (rd !== 32'h5) begin bad++; $display("FAIL underrun_isr: got %h exp 5", rd); end
        for (int i = 0; i < 5; i++) apb_write(5'h00, 32'h4000 + i, err);
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_0500) begin bad++; $display("FAIL clr_pre_status: got %h exp 00010500", rd); end
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h08; pwdata = 32'h11;
        @(negedge clk);
        penable = 1'b1; tx_ready = 1'b1;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b exp 0", tx_valid); end
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_0001) begin bad++; $display("FAIL clr_status: got %h exp 00010001", rd); end
        apb_read(5'h08, rd, err);
        total++; if (rd !== 32'h10) begin bad++; $display("FAIL clr_ctrl_rd: got %h exp 10", rd); end
        apb_read(5'h10, rd, err);
        total++; if (rd !== 32'h5) begin bad++; $display("FAIL clr_sticky: got %h exp 5", rd); end
        apb_write(5'h10, 32'h5, err);
        apb_read(5'h10, rd, err);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL w1c_live: got %h exp 1", rd); end
    endtask

    task automatic test_regs;
        apb_read(5'h14, rd, err);
        total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL unmapped_rd: got %b/%h exp 1/0", err, rd); end
        apb_read(5'h02, rd, err);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL unaligned_rd: got %b exp 1", err); end
        apb_write(5'h04, 32'hFFFF_FFFF, err);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL status_wr: got %b exp 1", err); end
        apb_write(5'h18, 32'h3F, err);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL unmapped_wr: got %b exp 1", err); end
        apb_read(5'h08, rd, err);
        total++; if (rd !== 32'h10 || err !== 1'b0) begin bad++; $display("FAIL unmapped_nochg: got %h/%b exp 10/0", rd, err); end
        apb_write(5'h0C, 32'hFFFF_FFFF, err);
        apb_read(5'h0C, rd, err);
        total++; if (rd !== 32'h001F_001F) begin bad++; $display("FAIL wmark_width: got %h exp 001f001f", rd); end
        apb_write(5'h08, 32'hFFFF_FFFF, err);
        apb_read(5'h08, rd, err);
        total++; if (rd !== 32'h0000_0F3A) begin bad++; $display("FAIL ctrl_bits: got %h exp 00000f3a", rd); end
        apb_write(5'h08, 32'h10, err);
        apb_write(5'h0C, 32'h4, err);
    endtask

    task automatic test_reset_midstream;
        apb_write(5'h0C, 32'h0002_0004, err);
        apb_write(5'h08, 32'h13A, err);
        for (int i = 0; i < 3; i++) apb_write(5'h00, 32'h6000 + i, err);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_valid = 1'b1; rx_data = 32'h7000 + i;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        total++; if ({tx_valid, tx_dma_req, rx_dma_req, irq} !== 4'b1111) begin
            bad++; $display("FAIL pre_reset_outs: got %b exp 1111", {tx_valid, tx_dma_req, rx_dma_req, irq});
        end
        #2 reset_n = 1'b0;
        #1;
        total++; if ({tx_valid, tx_dma_req, rx_dma_req, irq, pslverr} !== 5'b0) begin
            bad++; $display("FAIL async_reset_outs: got %b exp 00000", {tx_valid, tx_dma_req, rx_dma_req, irq, pslverr});
        end
        @(negedge clk);
        reset_n = 1'b1;
        apb_read(5'h04, rd, err);
        total++; if (rd !== 32'h0001_0001) begin bad++; $display("FAIL post_reset_status: got %h exp 00010001", rd); end
        apb_read(5'h08, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_reset_ctrl: got %h exp 0", rd); end
        apb_read(5'h0C, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_reset_wmark: got %h exp 0", rd); end
    endtask

    initial begin
        reset_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        tx_dma_ack = 1'b0; rx_dma_ack = 1'b0;
        test_reset();
        test_fill();
        test_dma();
        test_overrun();
        test_wrap();
        test_clear();
        test_regs();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
